merger: RTL and testbench

//  Element-wise merge of two equal-size feature-map partitions held in one shared on-chip RAM.
//  On a run pulse it streams both partitions through one read port.
//  It adds each co-located element pair and emits one write (result + address) per element.

---
 rtl/merger_if.sv | 55 +++++
 rtl/merger.sv | 220 ++++++++++++++++++++++
 tb/tb_merger.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/merger_if.sv
// -----------------------------------------------------------------------------
// merger_if
//   Bus bundle between the merger and its surroundings: the start pulse, the
//   shared partition RAM read port (address out, data in) and the merged-output
//   RAM write port (data, address, strobe) plus the end-of-pass pulse.
//
//   Parameters
//     DATA_WIDTH  element width (signed two's complement)
//     ADDR_WIDTH  RAM address width
//
//   Signals
//     run                start pulse towards the merger
//     data_in            partition RAM read data (2-cycle read latency)
//     read_address_out   partition RAM read address
//     result_out         merged element
//     write_address_out  destination address of result_out
//     write_en_out       1-cycle write strobe
//     done_out           1-cycle pulse on the last write of a pass
//
//   Modports
//     master  merger side: drives addresses, results and strobes
//     slave   environment side: drives run and the RAM read data
// -----------------------------------------------------------------------------
interface merger_if #(
    parameter int DATA_WIDTH = 27,
    parameter int ADDR_WIDTH = 10
);
    logic                  run;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] read_address_out;
    logic [DATA_WIDTH-1:0] result_out;
    logic [ADDR_WIDTH-1:0] write_address_out;
    logic                  write_en_out;
    logic                  done_out;

    modport master (
        input  run,
        input  data_in,
        output read_address_out,
        output result_out,
        output write_address_out,
        output write_en_out,
        output done_out
    );

    modport slave (
        output run,
        output data_in,
        input  read_address_out,
        input  result_out,
        input  write_address_out,
        input  write_en_out,
        input  done_out
    );
endinterface : merger_if

// File: rtl/merger.sv
// -----------------------------------------------------------------------------
// merger
//   Element-wise merge of two equal-size feature-map partitions that live in
//   one shared on-chip RAM. A run pulse streams both partitions through the
//   single read port, interleaved element by element (partition 0, then
//   partition 1), adds each co-located pair and emits one write per element
//   to the merged-output RAM at ADDRESS_0_IN + i.
//
//   Build option
//     MERGER_SATURATE_EN  defined:   sums clamp to the signed DATA_WIDTH range
//                         undefined: sums wrap modulo 2^DATA_WIDTH
//     Timing is identical in both builds.
//
//   Ports
//     clk    single clock, rising edge
//     reset  asynchronous, active-low reset (clears FSM, pipeline and outputs)
//     bus    merger_if.master: run, data_in in; read_address_out, result_out,
//            write_address_out, write_en_out, done_out out (all registered)
//
//   Timing (cycle 0 = first cycle after the edge that accepted run)
//     c = 0 .. 2N-1  read addresses A0+i (c = 2i) and A1+i (c = 2i+1)
//     c = 2i+2       partition-0 operand arrives, latched
//     c = 2i+3       partition-1 operand arrives, sum registered at end
//     c = 2i+4       write_en_out for element i; done_out with the last one
//     Run to done = 2N+3 cycles.
// -----------------------------------------------------------------------------
module merger #(
    parameter int PARTITION_WIDTH  = 5,
    parameter int PARTITION_HEIGHT = 5,
    parameter int DATA_WIDTH       = 27,
    parameter int ADDR_WIDTH       = 10,
    parameter int ADDRESS_0_IN     = 0,
    parameter int ADDRESS_1_IN     = 25
) (
    input  logic     clk,
    input  logic     reset,
    merger_if.master bus
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int N          = PARTITION_WIDTH * PARTITION_HEIGHT;
    localparam int LAST_CYCLE = 2 * N + 2;            // cycle carrying the last write
    localparam int CW         = $clog2(LAST_CYCLE + 1);

    typedef logic [CW-1:0]         cnt_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam addr_t BASE_0      = addr_t'(ADDRESS_0_IN);
    localparam addr_t BASE_1      = addr_t'(ADDRESS_1_IN);
    localparam cnt_t  ISSUE_LAST  = cnt_t'(2 * N - 1);
    localparam cnt_t  LAST_SUM    = cnt_t'(2 * N + 1); // sum cycle of element N-1
    localparam cnt_t  DRAIN_LAST  = cnt_t'(LAST_CYCLE);
    localparam cnt_t  FIRST_DATA  = cnt_t'(2);         // read latency of the RAM

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and pipeline registers
    // -------------------------------------------------------------------------
    state_t state_q,        state_d;
    cnt_t   cnt_q,          cnt_d;          // cycle index c within the pass
    addr_t  read_addr_q,    read_addr_d;
    data_t  op0_q,          op0_d;          // partition-0 operand of current pair
    data_t  result_q,       result_d;
    addr_t  write_addr_q,   write_addr_d;
    logic   write_en_q,     write_en_d;
    logic   done_q,         done_d;

    // -------------------------------------------------------------------------
    // Pair sum, reduced to DATA_WIDTH
    // -------------------------------------------------------------------------
    data_t sum_red;

`ifdef MERGER_SATURATE_EN
    // One extra bit holds the exact sum; a disagreement between the two top
    // bits means the DATA_WIDTH result overflowed, and the top bit gives the
    // true sign to clamp towards.
    logic [DATA_WIDTH:0] sum_full;

    always_comb begin
        sum_full = {op0_q[DATA_WIDTH-1], op0_q}
                 + {bus.data_in[DATA_WIDTH-1], bus.data_in};
        if (sum_full[DATA_WIDTH] != sum_full[DATA_WIDTH-1]) begin
            sum_red = sum_full[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            sum_red = sum_full[DATA_WIDTH-1:0];
        end
    end
`else
    // Keeping only the low DATA_WIDTH bits of the exact sum is the same as a
    // DATA_WIDTH-wide add, so no carry bit is formed at all.
    always_comb begin
        sum_red = op0_q + bus.data_in;
    end
`endif

    // -------------------------------------------------------------------------
    // Address helpers
    // -------------------------------------------------------------------------
    cnt_t  next_c;          // cycle index of the next cycle
    addr_t read_idx;        // element index read in the next cycle
    addr_t write_idx;       // element index whose sum is formed this cycle

    always_comb begin
        next_c    = cnt_q + cnt_t'(1);
        read_idx  = addr_t'(next_c >> 1);
        // Sum cycles are c = 2i+3, so i = (c-3)/2; only used when c >= 3.
        write_idx = addr_t'((cnt_q - cnt_t'(3)) >> 1);
    end

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        read_addr_d  = read_addr_q;
        op0_d        = op0_q;
        result_d     = result_q;
        write_addr_d = write_addr_q;
        write_en_d   = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d     = S_ISSUE;
                    cnt_d       = '0;
                    read_addr_d = BASE_0;   // visible in cycle 0
                end
            end

            S_ISSUE: begin
                cnt_d = next_c;
                if (cnt_q == ISSUE_LAST) begin
                    // All reads issued; the address simply holds from here.
                    state_d = S_DRAIN;
                end else begin
                    // Odd cycles read partition 1, even cycles partition 0.
                    read_addr_d = next_c[0] ? (BASE_1 + read_idx)
                                            : (BASE_0 + read_idx);
                end
            end

            S_DRAIN: begin
                cnt_d = next_c;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Operand pipeline: read data trails the issued address by two
        // cycles, so from c = 2 on even cycles carry partition-0 data and odd
        // cycles carry the matching partition-1 data.
        if ((state_q != S_IDLE) && (cnt_q >= FIRST_DATA)) begin
            if (!cnt_q[0]) begin
                op0_d = bus.data_in;
            end else begin
                result_d     = sum_red;
                write_addr_d = BASE_0 + write_idx;
                write_en_d   = 1'b1;
                done_d       = (cnt_q == LAST_SUM);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            read_addr_q  <= '0;
            op0_q        <= '0;
            result_q     <= '0;
            write_addr_q <= '0;
            write_en_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values from before this edge, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_addr_q  <= read_addr_d;
            op0_q        <= op0_d;
            result_q     <= result_d;
            write_addr_q <= write_addr_d;
            write_en_q   <= write_en_d;
            done_q       <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -------------------------------------------------------------------------
    assign bus.read_address_out  = read_addr_q;
    assign bus.result_out        = result_q;
    assign bus.write_address_out = write_addr_q;
    assign bus.write_en_out      = write_en_q;
    assign bus.done_out          = done_q;

endmodule : merger

// File: tb/tb_merger.sv
// -----------------------------------------------------------------------------
// tb_merger
//   Self-checking bench for merger. A behavioural RAM with a 2-register read
//   path feeds data_in. Each run pulse pushes the expected write sequence of a
//   pass into a scoreboard queue; a monitor pops and compares on every write
//   strobe. Directed steps cover reset, a plain pass, run pulses mid-pass,
//   reset mid-pass, overflow/negative sums and run held high.
//   Build with +define+MERGER_SATURATE_EN to check the clamping build.
// -----------------------------------------------------------------------------
module tb_merger;

    localparam int PW  = 5;
    localparam int PH  = 5;
    localparam int N   = PW * PH;
    localparam int DW  = 27;
    localparam int AW  = 10;
    localparam int A0  = 0;
    localparam int A1  = 25;

    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    merger_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    merger #(
        .PARTITION_WIDTH (PW),
        .PARTITION_HEIGHT(PH),
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .ADDRESS_0_IN    (A0),
        .ADDRESS_1_IN    (A1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- RAM model: two register stages on the read path -------
    logic [DW-1:0] ram [0:63];
    logic [DW-1:0] rd_pipe1 = '0;
    logic [DW-1:0] rd_pipe2 = '0;

    always @(posedge clk) begin
        rd_pipe1 <= ram[bus.read_address_out[5:0]];
        rd_pipe2 <= rd_pipe1;
    end

    assign bus.data_in = rd_pipe2;

    // ---------------- bookkeeping ----------------
    int   n_checks       = 0;
    int   n_errors       = 0;
    int   n_writes       = 0;
    int   cyc            = 0;
    int   last_write_cyc = -1;
    exp_t sb [$];
    logic [DW-1:0] res_log [0:N-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef MERGER_SATURATE_EN
        if (s > MAXV) s = MAXV;
        else if (s < MINV) s = MINV;
`endif
        return DW'(s);
    endfunction

    function automatic void push_pass();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.addr = AW'(A0 + i);
            e.data = model_sum(ram[A0 + i], ram[A1 + i]);
            e.done = (i == N - 1);
            sb.push_back(e);
        end
    endfunction

    // ---------------- write monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && bus.write_en_out) begin
            n_writes++;
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("write_addr", 64'(bus.write_address_out), 64'(e.addr));
                check("result",     64'(bus.result_out),        64'(e.data));
                check("done_flag",  64'(bus.done_out),          64'(e.done));
                if (int'(e.addr) != A0)
                    check("write_spacing", 64'(cyc - last_write_cyc), 64'd2);
                res_log[int'(e.addr) - A0] = bus.result_out;
            end
            last_write_cyc = cyc;
        end
        if (reset && bus.done_out)
            check("done_with_we", 64'(bus.write_en_out), 64'd1);
    end

    // ---------------- helpers ----------------
    task automatic init_ram();
        for (int k = 0; k < 64; k++) ram[k] = (k < 50) ? DW'(k + 1) : '0;
    endtask

    // Returns the cycle counter value seen during cycle 0 of the pass.
    task automatic pulse_run(output int start);
        @(negedge clk);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        start = cyc;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done_out) begin
                at = cyc;
                break;
            end
        end
        check("done_seen", 64'(at >= 0), 64'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_addr"}, 64'(bus.read_address_out),  64'd0);
        check({tag, "_result"},  64'(bus.result_out),        64'd0);
        check({tag, "_wr_addr"}, 64'(bus.write_address_out), 64'd0);
        check({tag, "_we"},      64'(bus.write_en_out),      64'd0);
        check({tag, "_done"},    64'(bus.done_out),          64'd0);
    endtask

    task automatic plain_pass(input string tag);
        int start, d, w0;
        w0 = n_writes;
        push_pass();
        pulse_run(start);
        wait_done(200, d);
        check({tag, "_latency"}, 64'(d - start), 64'(2 * N + 2));
        repeat (5) @(negedge clk);
        check({tag, "_writes"},   64'(n_writes - w0), 64'(N));
        check({tag, "_sb_empty"}, 64'(sb.size()),     64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int start, d, d1, d2, w0, budget;

        bus.run = 1'b0;
        init_ram();

        // Reset state
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;

        // 1: plain pass, results 27, 29, ..., 75
        plain_pass("s1");
        check("s1_first_result", 64'(res_log[0]),     64'd27);
        check("s1_last_result",  64'(res_log[N - 1]), 64'd75);

        // 2: run pulses in ISSUE and DRAIN are ignored
        w0 = n_writes;
        push_pass();
        pulse_run(start);
        repeat (8) @(negedge clk);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        while (cyc < start + 2 * N + 1) @(negedge clk);
        bus.run = 1'b1;                       // cycle 2N+1, DRAIN
        @(negedge clk);
        bus.run = 1'b0;
        check("s2_done_cycle", 64'(bus.done_out), 64'd1);
        repeat (60) @(negedge clk);
        check("s2_writes",   64'(n_writes - w0),          64'(N));
        check("s2_sb_empty", 64'(sb.size()),              64'd0);
        check("s2_rd_hold",  64'(bus.read_address_out),   64'(A1 + N - 1));
        check("s2_we_idle",  64'(bus.write_en_out),       64'd0);

        // 3: reset at write #10, then a fresh pass
        w0 = n_writes;
        push_pass();
        pulse_run(start);
        budget = 0;
        while ((n_writes - w0) < 10 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("s3_reached_write10", 64'(n_writes - w0), 64'd10);
        #1 reset = 1'b0;
        #1 check_outputs_zero("s3_async");
        sb.delete();
        w0 = n_writes;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("s3_no_writes", 64'(n_writes - w0), 64'd0);
        plain_pass("s3_rerun");
        check("s3_first_result", 64'(res_log[0]),     64'd27);
        check("s3_last_result",  64'(res_log[N - 1]), 64'd75);

        // 4 + 5: overflow at element 0, negative sum at element 1
        ram[0]  = DW'(27'h3FF_FFFF);          // 2^26 - 1
        ram[25] = DW'(1);
        ram[1]  = DW'(-5);
        ram[26] = DW'(3);
        plain_pass("s45");
`ifdef MERGER_SATURATE_EN
        check("s4_overflow", 64'(res_log[0]), 64'(27'h3FF_FFFF));
`else
        check("s4_overflow", 64'(res_log[0]), 64'(27'h400_0000));
`endif
        check("s5_negative", 64'(res_log[1]), 64'(27'h7FF_FFFE));
        init_ram();

        // 6: run held high gives back-to-back identical passes
        w0 = n_writes;
        push_pass();
        push_pass();
        @(negedge clk);
        bus.run = 1'b1;
        wait_done(200, d1);
        wait_done(200, d2);
        bus.run = 1'b0;
        check("s6_pass_period", 64'(d2 - d1), 64'(2 * N + 4));
        repeat (60) @(negedge clk);
        check("s6_writes",   64'(n_writes - w0), 64'(2 * N));
        check("s6_sb_empty", 64'(sb.size()),     64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_merger
